branch_predict_unit: RTL and testbench

Parametrised branch unit for the RISC-V core. It combines a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It predicts at fetch, then resolves branches and jumps in EX using the existing Branch/JSel/JalrSel semantics, and raises a redirect on misprediction. It sits between the IF-stage PC mux and the EX stage, and replaces the purely combinational EX-stage branch decision.

---
 rtl/branch_pkg.sv | 35 +++
 rtl/btb_table.sv | 38 +++
 rtl/branch_predict_unit.sv | 107 ++++++++++
 tb/tb_branch_predict_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch predictor: direction counter encoding, BTB entry
// layout and the saturating counter step.
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Tags are held zero-extended to a fixed width so the struct stays parameter-free.
  localparam int TAG_MAX_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    ctr_t                 ctr;
  } btb_entry_t;

  localparam btb_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

  function automatic ctr_t ctr_next(ctr_t ctr, logic taken);
    ctr_t result;
    result = ctr;
    if (taken) begin
      if (ctr != ST) result = ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != SNT) result = ctr_t'(ctr - 2'd1);
    end
    return result;
  endfunction

endpackage

// File: rtl/btb_table.sv
// BTB/direction-counter storage: two asynchronous read ports (fetch and EX),
// one synchronous write port, asynchronous reset to invalid/WNT.
module btb_table
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_a,
  output btb_entry_t       rd_entry_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output btb_entry_t       rd_entry_b,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  btb_entry_t entries [DEPTH];

  // Registers rather than block RAM: reads are combinational and reset clears every entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entries[gi] <= ENTRY_RESET;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          entries[gi] <= wr_entry;
        end
      end
    end
  endgenerate

  assign rd_entry_a = entries[rd_idx_a];
  assign rd_entry_b = entries[rd_idx_b];

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-time BTB prediction plus EX-stage branch/jump resolution, misprediction
// redirect and saturating statistics.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int BTB_DEPTH = 16,
  parameter int IDX_W     = $clog2(BTB_DEPTH),
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   IF_PC,
  output logic              Pred_Taken,
  output logic [31:0]       Pred_Target,
  input  logic              Ex_Valid,
  input  logic [PC_W-1:0]   Ex_PC,
  input  logic [31:0]       Ex_Imm,
  input  logic              Ex_Branch,
  input  logic              Ex_JSel,
  input  logic              Ex_JalrSel,
  input  logic [31:0]       Ex_AluResult,
  input  logic              Ex_PredTaken,
  input  logic [31:0]       Ex_PredTarget,
  output logic [31:0]       PC_Four,
  output logic [31:0]       PC_Imm,
  output logic              Mispredict,
  output logic [31:0]       Redirect_PC,
  output logic [STAT_W-1:0] Br_Count,
  output logic [STAT_W-1:0] Miss_Count
);

  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  btb_entry_t       if_entry, ex_entry, wr_entry;
  logic             if_hit, ex_hit, wr_en;
  logic             resolving, act_taken;
  logic [31:0]      ex_pc32, act_target;
  logic             unused_bits;

  assign if_idx      = IF_PC[IDX_W+1:2];
  assign if_tag      = IF_PC[PC_W-1:IDX_W+2];
  assign ex_idx      = Ex_PC[IDX_W+1:2];
  assign ex_tag      = Ex_PC[PC_W-1:IDX_W+2];
  assign unused_bits = ^IF_PC[1:0];

  btb_table #(
    .DEPTH (BTB_DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_a   (if_idx),
    .rd_entry_a (if_entry),
    .rd_idx_b   (ex_idx),
    .rd_entry_b (ex_entry),
    .wr_en      (wr_en),
    .wr_idx     (ex_idx),
    .wr_entry   (wr_entry)
  );

  assign if_hit      = if_entry.valid && (if_entry.tag == TAG_MAX_W'(if_tag));
  assign Pred_Taken  = if_hit && if_entry.ctr[1];
  assign Pred_Target = Pred_Taken ? if_entry.target : 32'd0;

  assign ex_pc32     = 32'(Ex_PC);
  assign PC_Four     = ex_pc32 + 32'd4;
  assign PC_Imm      = Ex_JalrSel ? Ex_AluResult : ex_pc32 + Ex_Imm;
  assign act_target  = PC_Imm;
  assign resolving   = Ex_Valid && (Ex_Branch || Ex_JSel);
  assign act_taken   = Ex_JSel || (Ex_Branch && Ex_AluResult[0]);
  assign Mispredict  = resolving && ((act_taken != Ex_PredTaken) ||
                                     (act_taken && (Ex_PredTarget != act_target)));
  assign Redirect_PC = !Mispredict ? 32'd0 : (act_taken ? act_target : PC_Four);

  assign ex_hit = ex_entry.valid && (ex_entry.tag == TAG_MAX_W'(ex_tag));

  // Not-taken misses leave the table alone so a cold branch cannot evict a useful entry.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = ex_entry;
    if (resolving) begin
      if (ex_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_next(ex_entry.ctr, act_taken);
        if (act_taken) wr_entry.target = act_target;
      end else if (act_taken) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: TAG_MAX_W'(ex_tag), target: act_target,
                     ctr: (Ex_JSel ? ST : WT)};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Br_Count   <= '0;
      Miss_Count <= '0;
    end else begin
      if (resolving && (Br_Count != '1)) Br_Count <= Br_Count + STAT_W'(1);
      if (Mispredict && (Miss_Count != '1)) Miss_Count <= Miss_Count + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed table-driven bench for branch_predict_unit plus hand sequences for
// asynchronous reset and statistics saturation (second instance with STAT_W=4).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  if_pc = '0;
  logic        ex_valid = 1'b0;
  logic [8:0]  ex_pc = '0;
  logic [31:0] ex_imm = '0;
  logic        ex_branch = 1'b0, ex_jsel = 1'b0, ex_jalrsel = 1'b0;
  logic [31:0] ex_alu = '0;
  logic        ex_ptk = 1'b0;
  logic [31:0] ex_ptg = '0;

  logic        pred_taken, mispredict;
  logic [31:0] pred_target, pc_four, pc_imm, redirect_pc;
  logic [15:0] br_count, miss_count;

  logic        pred_taken4, mispredict4;
  logic [31:0] pred_target4, pc_four4, pc_imm4, redirect_pc4;
  logic [3:0]  br_count4, miss_count4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .IF_PC(if_pc),
    .Pred_Taken(pred_taken), .Pred_Target(pred_target),
    .Ex_Valid(ex_valid), .Ex_PC(ex_pc), .Ex_Imm(ex_imm),
    .Ex_Branch(ex_branch), .Ex_JSel(ex_jsel), .Ex_JalrSel(ex_jalrsel),
    .Ex_AluResult(ex_alu), .Ex_PredTaken(ex_ptk), .Ex_PredTarget(ex_ptg),
    .PC_Four(pc_four), .PC_Imm(pc_imm), .Mispredict(mispredict),
    .Redirect_PC(redirect_pc), .Br_Count(br_count), .Miss_Count(miss_count)
  );

  branch_predict_unit #(.STAT_W(4)) dut4 (
    .clk(clk), .reset(reset), .IF_PC(if_pc),
    .Pred_Taken(pred_taken4), .Pred_Target(pred_target4),
    .Ex_Valid(ex_valid), .Ex_PC(ex_pc), .Ex_Imm(ex_imm),
    .Ex_Branch(ex_branch), .Ex_JSel(ex_jsel), .Ex_JalrSel(ex_jalrsel),
    .Ex_AluResult(ex_alu), .Ex_PredTaken(ex_ptk), .Ex_PredTarget(ex_ptg),
    .PC_Four(pc_four4), .PC_Imm(pc_imm4), .Mispredict(mispredict4),
    .Redirect_PC(redirect_pc4), .Br_Count(br_count4), .Miss_Count(miss_count4)
  );

  typedef struct {
    logic        ev, br, js, jr;
    logic [8:0]  pc;
    logic [31:0] imm, alu;
    logic        ptk;
    logic [31:0] ptg;
    logic [8:0]  ifpc;
    logic        mis;
    logic [31:0] rdr, p4, pimm;
    logic        etk;
    logic [31:0] etg;
    logic [15:0] bc, mc;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jsel = 1'b0; ex_jalrsel = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_alu = '0; ex_ptk = 1'b0; ex_ptg = '0;
  endtask

  initial begin
    //           ev    br    js    jr    pc      imm     alu      ptk   ptg      ifpc    mis   rdr      p4      pimm     etk   etg     bc  mc
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h00, 32'h00, 32'h000, 1'b0, 32'h00, 9'h40, 1'b0, 32'h000, 32'h04, 32'h000, 1'b0, 32'h00, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h20, 32'h10, 32'h001, 1'b0, 32'h00, 9'h20, 1'b1, 32'h030, 32'h24, 32'h030, 1'b0, 32'h00, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h20, 32'h10, 32'h000, 1'b0, 32'h00, 9'h20, 1'b0, 32'h000, 32'h24, 32'h030, 1'b1, 32'h30, 1, 1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h20, 32'h10, 32'h000, 1'b1, 32'h30, 9'h20, 1'b1, 32'h024, 32'h24, 32'h030, 1'b1, 32'h30, 1, 1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h20, 32'h10, 32'h000, 1'b0, 32'h00, 9'h20, 1'b0, 32'h000, 32'h24, 32'h030, 1'b0, 32'h00, 2, 2};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h20, 32'h10, 32'h000, 1'b0, 32'h00, 9'h20, 1'b0, 32'h000, 32'h24, 32'h030, 1'b0, 32'h00, 3, 2};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'h08, 32'h78, 32'h000, 1'b0, 32'h00, 9'h08, 1'b1, 32'h080, 32'h0c, 32'h080, 1'b0, 32'h00, 3, 2};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 9'h08, 32'h78, 32'h100, 1'b1, 32'h80, 9'h08, 1'b1, 32'h100, 32'h0c, 32'h100, 1'b1, 32'h80, 4, 3};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 9'h08, 32'h78, 32'h100, 1'b1, 32'h100, 9'h08, 1'b0, 32'h000, 32'h0c, 32'h100, 1'b1, 32'h100, 5, 4};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h48, 32'h08, 32'h000, 1'b0, 32'h00, 9'h08, 1'b0, 32'h000, 32'h4c, 32'h050, 1'b1, 32'h100, 6, 4};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 9'h48, 32'h08, 32'h001, 1'b0, 32'h00, 9'h08, 1'b0, 32'h000, 32'h4c, 32'h050, 1'b1, 32'h100, 7, 4};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h48, 32'h08, 32'h001, 1'b0, 32'h00, 9'h48, 1'b1, 32'h050, 32'h4c, 32'h050, 1'b0, 32'h00, 7, 4};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h00, 32'h00, 32'h000, 1'b0, 32'h00, 9'h08, 1'b0, 32'h000, 32'h04, 32'h000, 1'b0, 32'h00, 8, 5};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h00, 32'h00, 32'h000, 1'b0, 32'h00, 9'h48, 1'b0, 32'h000, 32'h04, 32'h000, 1'b1, 32'h50, 8, 5};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_br_count", 0, 32'(br_count), 32'd0);
    check("reset_miss_count", 0, 32'(miss_count), 32'd0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ex_valid = vecs[i].ev; ex_branch = vecs[i].br; ex_jsel = vecs[i].js;
      ex_jalrsel = vecs[i].jr; ex_pc = vecs[i].pc; ex_imm = vecs[i].imm;
      ex_alu = vecs[i].alu; ex_ptk = vecs[i].ptk; ex_ptg = vecs[i].ptg;
      if_pc = vecs[i].ifpc;
      #1;
      $display("[TB] vec %0d if_pc=%h ex_pc=%h pred=%0b/%h mis=%0b rdr=%h br=%0d miss=%0d",
               i, if_pc, ex_pc, pred_taken, pred_target, mispredict, redirect_pc,
               br_count, miss_count);
      check("mispredict", i, 32'(mispredict), 32'(vecs[i].mis));
      check("redirect_pc", i, redirect_pc, vecs[i].rdr);
      check("pc_four", i, pc_four, vecs[i].p4);
      check("pc_imm", i, pc_imm, vecs[i].pimm);
      check("pred_taken", i, 32'(pred_taken), 32'(vecs[i].etk));
      check("pred_target", i, pred_target, vecs[i].etg);
      check("br_count", i, 32'(br_count), 32'(vecs[i].bc));
      check("miss_count", i, 32'(miss_count), 32'(vecs[i].mc));
      check("br_count4", i, 32'(br_count4), 32'(vecs[i].bc));
    end

    // Asynchronous reset in the middle of a resolving cycle.
    @(negedge clk);
    ex_valid = 1'b1; ex_branch = 1'b1; ex_jsel = 1'b0; ex_jalrsel = 1'b0;
    ex_pc = 9'h40; ex_imm = 32'h10; ex_alu = 32'h1; ex_ptk = 1'b0; ex_ptg = '0;
    if_pc = 9'h48;
    #1;
    $display("[TB] pre-reset pred=%0b/%h", pred_taken, pred_target);
    check("prereset_pred_taken", 0, 32'(pred_taken), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    $display("[TB] mid-reset pred=%0b/%h mis=%0b br=%0d", pred_taken, pred_target,
             mispredict, br_count);
    check("midreset_pred_taken", 0, 32'(pred_taken), 32'd0);
    check("midreset_pred_target", 0, pred_target, 32'd0);
    check("midreset_br_count", 0, 32'(br_count), 32'd0);
    check("midreset_miss_count", 0, 32'(miss_count), 32'd0);
    check("midreset_mispredict", 0, 32'(mispredict), 32'd1);
    check("midreset_redirect", 0, redirect_pc, 32'h50);
    @(negedge clk);
    clear_ex();
    reset = 1'b0;
    if_pc = 9'h08;
    #1;
    $display("[TB] post-reset if_pc=08 pred=%0b/%h br=%0d", pred_taken, pred_target, br_count);
    check("postreset_pred_08", 0, 32'(pred_taken), 32'd0);
    check("postreset_br_count", 0, 32'(br_count), 32'd0);
    if_pc = 9'h40;
    #1;
    check("postreset_pred_40", 0, 32'(pred_taken), 32'd0);

    // 20 correctly predicted not-taken resolutions: the 4-bit counter must saturate.
    @(negedge clk);
    ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = 9'h60; ex_imm = 32'h20; ex_alu = 32'h0;
    repeat (20) @(negedge clk);
    clear_ex();
    #1;
    $display("[TB] saturation br4=%0d miss4=%0d br16=%0d", br_count4, miss_count4, br_count);
    check("sat_br_count4", 0, 32'(br_count4), 32'hF);
    check("sat_miss_count4", 0, 32'(miss_count4), 32'h0);
    check("sat_br_count16", 0, 32'(br_count), 32'd20);
    if_pc = 9'h60;
    #1;
    check("nt_miss_no_alloc", 0, 32'(pred_taken), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
